writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Shares the two register-file write ports among the functional-unit result sources of the dual-issue out-of-order core: both adders, both multipliers and both load units. Each cycle it grants up to two ready results, chosen round-robin, and drives registered write-port signals to the register file. Destination conflicts within a cycle are resolved so that results retire in grant order. It sits between the functional units and the register file, replacing ad hoc per-unit write enables.

## Interface
- N_REQ, 6, number of result requesters; index order is ADD1, ADD2, MUL1, MUL2, LOAD1, LOAD2.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- stall  in  1  register file unavailable; no grants this cycle.
- req_valid  in  N_REQ  requester i holds a result.
- req_rd  in  N_REQ×5  destination register per requester.
- req_data  in  N_REQ×32  result value per requester.
- req_ready  out  N_REQ  combinational grant; the transfer completes when valid and ready are both high at clk.
- wb_en0, wb_en1  out  1  write enable for port 0 and port 1 (registered).
- wb_rd0, wb_rd1  out  5  write address (registered).
- wb_data0, wb_data1  out  32  write data (registered).

## Operation
- Internal rotating pointer `ptr`, range 0..N_REQ-1.
- Scan order: ptr, ptr+1, … modulo N_REQ.
- First grant g0: the first index in scan order with req_valid set.
- Second grant g1: the next valid index after g0 in scan order, with one exclusion.
  - The index is skipped if its req_rd equals req_rd[g0] and that register is nonzero.
  - Scanning continues past skipped indices.
- A requester that is skipped keeps its valid asserted and is granted in a later cycle.
- Port mapping: g0 drives port 0 and g1 drives port 1. Port 0 is always the older grant in scan order.
- Destination register 0:
  - The request is granted and consumed normally.
  - The corresponding wb_en is 0; wb_rd and wb_data still load.
  - Two rd=0 requests may both be granted in the same cycle.
- Pointer update:
  - If any grant, ptr ← (last granted index + 1) mod N_REQ.
  - If no grant, ptr is held.
- stall=1:
  - req_ready is all 0.
  - wb_en0 and wb_en1 are 0 next cycle.
  - ptr is held.
  - wb_rd and wb_data hold their previous values.
- Requesters must not make req_valid depend on req_ready. Once valid is raised, the requester holds valid, rd and data stable until the handshake completes.
- Reset values:
  - ptr=0.
  - All wb_* outputs 0.
  - req_ready is 0 while reset is asserted.
- Reset mid-operation: registered writebacks in flight are dropped (wb_en forced to 0). Requesters re-present after reset.

## Timing
- Grant latency is 0 cycles: req_ready is combinational from req_valid, req_rd, stall and ptr.
- Writeback latency is 1 cycle: a handshake at edge k drives wb_* valid for the cycle after edge k.
- Throughput: at most 2 results per cycle.
- Fairness: with all N_REQ requesters continuously valid and distinct rd values, every requester is granted within ceil(N_REQ/2) cycles.
- Simultaneous events:
  - stall overrides all grants.
  - Reset overrides everything, asynchronously.
- Pointer wrap-around: after the last index N_REQ-1 is granted, ptr becomes 0.

## Structure
- Package `wb_pkg` holds:
  - N_REQ default.
  - Requester index enum: REQ_ADD1=0, REQ_ADD2, REQ_MUL1, REQ_MUL2, REQ_LOAD1, REQ_LOAD2.
  - Packed struct `wb_port_t` with fields {en, rd[4:0], data[31:0]}.
- Sub-module `rr_pick`: combinational find-first-set over a mask, starting from a given index, modulo N_REQ.
  - Outputs a found flag and the selected index.
  - Instantiated twice: once for g0, and once for g1 with a mask excluding g0 and any rd-conflicting requesters.
- The top level holds ptr, the output registers and the ready decode.

## Test plan
- Reset asserted mid-run with wb_en0=1 → all wb_* are 0 immediately, ptr=0, req_ready=0.
- Single requester: REQ_ADD1 valid, rd=5, data=0x11 → req_ready[0]=1 the same cycle; next cycle wb_en0=1, wb_rd0=5, wb_data0=0x11, wb_en1=0; ptr=1.
- All six valid with rd=1..6, each reasserting after its handshake:
  - Grants are {0,1}, {2,3}, {4,5}, {0,1} on consecutive cycles.
  - Port 0 carries the even index.
- Conflict: REQ_MUL1 and REQ_MUL2 both rd=7, ptr=0:
  - Cycle 1: only req_ready[2]=1.
  - Cycle 2: req_ready[3]=1.
  - wb_data order matches the grant order.
- Zero destination: REQ_LOAD1 with rd=0, data=0xFF, together with REQ_LOAD2 with rd=9, data=0x22:
  - Both are granted.
  - Next cycle wb_en0=0, wb_en1=1, wb_rd1=9, wb_data1=0x22.
- Stall:
  - stall=1 for 3 cycles with REQ_ADD2, REQ_MUL1 and REQ_LOAD2 valid → req_ready=0 and wb_en=0 throughout; ptr unchanged.
  - On release, the first grants start from the held ptr.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package wb_pkg;

    localparam int unsigned N_REQ_DEF = 6;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned DATA_W    = 32;

    // Requester index order as wired into the arbiter's request vectors.
    typedef enum logic [2:0] {
        REQ_ADD1  = 3'd0,
        REQ_ADD2  = 3'd1,
        REQ_MUL1  = 3'd2,
        REQ_MUL2  = 3'd3,
        REQ_LOAD1 = 3'd4,
        REQ_LOAD2 = 3'd5
    } req_idx_e;

    // One registered register-file write port.
    typedef struct packed {
        logic              en;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } wb_port_t;

    // Register 0 is hardwired, so writes to it are never enabled.
    function automatic logic rd_writes(input logic [RD_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating find-first-set: returns the first set bit of mask_i at or after start_i,
// wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 6,
    parameter int unsigned W = 3
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] start_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    // Scan from the far end back toward start_i so the nearest hit wins.
    always_comb begin
        int          pos;
        logic [W-1:0] pos_w;
        found_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        pos_w   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos   = (int'(start_i) + k) % int'(N);
            pos_w = W'(pos);
            if (mask_i[pos_w]) begin
                found_o = 1'b1;
                idx_o   = pos_w;
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Round-robin arbiter granting up to two functional-unit results per cycle onto
// the two register-file write ports, with same-cycle destination conflicts deferred.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][RD_W-1:0]    req_rd,
    input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          wb_en0,
    output logic                          wb_en1,
    output logic [RD_W-1:0]               wb_rd0,
    output logic [RD_W-1:0]               wb_rd1,
    output logic [DATA_W-1:0]             wb_data0,
    output logic [DATA_W-1:0]             wb_data1
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found0, found1;
    logic [IDX_W-1:0] g0, g1, g0_next, last_idx;
    logic [N_REQ-1:0] mask1;
    logic             gnt_ok;
    wb_port_t         port0_q, port0_d, port1_q, port1_d;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (int'(i) == int'(N_REQ) - 1) begin
            return '0;
        end
        return i + IDX_W'(1);
    endfunction

    rr_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_pick0 (
        .mask_i  (req_valid),
        .start_i (ptr_q),
        .found_o (found0),
        .idx_o   (g0)
    );

    // Second-grant candidates: valid, not g0, and not writing g0's nonzero destination.
    always_comb begin
        mask1 = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            mask1[i] = req_valid[i] && (IDX_W'(i) != g0) &&
                       !((req_rd[i] == req_rd[g0]) && rd_writes(req_rd[g0]));
        end
    end

    assign g0_next = wrap_inc(g0);

    rr_pick #(
        .N (N_REQ),
        .W (IDX_W)
    ) u_pick1 (
        .mask_i  (mask1),
        .start_i (g0_next),
        .found_o (found1),
        .idx_o   (g1)
    );

    assign gnt_ok   = found0 && !stall && !reset;
    assign last_idx = found1 ? g1 : g0;

    // Ready decode: one-hot per granted index, nothing under stall or reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            req_ready[i] = gnt_ok && ((g0 == IDX_W'(i)) || (found1 && (g1 == IDX_W'(i))));
        end
    end

    // Next pointer and write-port contents; rd/data hold when a port is idle.
    always_comb begin
        ptr_d      = ptr_q;
        port0_d    = port0_q;
        port1_d    = port1_q;
        port0_d.en = 1'b0;
        port1_d.en = 1'b0;
        if (!stall && found0) begin
            ptr_d        = wrap_inc(last_idx);
            port0_d.en   = rd_writes(req_rd[g0]);
            port0_d.rd   = req_rd[g0];
            port0_d.data = req_data[g0];
            if (found1) begin
                port1_d.en   = rd_writes(req_rd[g1]);
                port1_d.rd   = req_rd[g1];
                port1_d.data = req_data[g1];
            end
        end
    end

    // State registers; reset drops any writeback in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            port0_q <= '0;
            port1_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            port0_q <= port0_d;
            port1_q <= port1_d;
        end
    end

    assign wb_en0   = port0_q.en;
    assign wb_rd0   = port0_q.rd;
    assign wb_data0 = port0_q.data;
    assign wb_en1   = port1_q.en;
    assign wb_rd1   = port1_q.rd;
    assign wb_data1 = port1_q.data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: a queue-based scan model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_writeback_arbiter;

    localparam int N = 6;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 stall;
    logic [N-1:0]         req_valid;
    logic [N-1:0][4:0]    req_rd;
    logic [N-1:0][31:0]   req_data;
    logic [N-1:0]         req_ready;
    logic                 wb_en0, wb_en1;
    logic [4:0]           wb_rd0, wb_rd1;
    logic [31:0]          wb_data0, wb_data1;

    int total = 0;
    int bad   = 0;

    writeback_arbiter #(
        .N_REQ (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_en0    (wb_en0),
        .wb_en1    (wb_en1),
        .wb_rd0    (wb_rd0),
        .wb_rd1    (wb_rd1),
        .wb_data0  (wb_data0),
        .wb_data1  (wb_data1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit f0;
        bit f1;
        int g0;
        int g1;
    } pick_t;

    // List valid requesters in scan order; first is g0, first later one without a
    // nonzero destination clash with g0 is g1.
    function automatic pick_t model_pick(input int p, input logic [N-1:0] v,
                                         input logic [N-1:0][4:0] rd);
        pick_t r;
        int    order[$];
        r = '{f0: 0, f1: 0, g0: 0, g1: 0};
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) order.push_back((p + k) % N);
        end
        if (order.size() > 0) begin
            r.f0 = 1;
            r.g0 = order[0];
            for (int j = 1; j < order.size(); j++) begin
                if (rd[order[j]] != rd[r.g0] || rd[r.g0] == 5'd0) begin
                    r.f1 = 1;
                    r.g1 = order[j];
                    break;
                end
            end
        end
        return r;
    endfunction

    int          mptr = 0;
    logic        m_en0 = 0, m_en1 = 0;
    logic [4:0]  m_rd0 = 0, m_rd1 = 0;
    logic [31:0] m_d0 = 0, m_d1 = 0;

    function automatic logic [N-1:0] model_ready();
        pick_t        pk;
        logic [N-1:0] r;
        r = '0;
        if (reset !== 1'b0 || stall) return r;
        pk = model_pick(mptr, req_valid, req_rd);
        if (pk.f0) r[pk.g0] = 1'b1;
        if (pk.f1) r[pk.g1] = 1'b1;
        return r;
    endfunction

    always @(posedge clk or posedge reset) begin
        pick_t pk;
        if (reset) begin
            mptr  <= 0;
            m_en0 <= 0; m_en1 <= 0;
            m_rd0 <= 0; m_rd1 <= 0;
            m_d0  <= 0; m_d1  <= 0;
        end else begin
            m_en0 <= 0;
            m_en1 <= 0;
            if (!stall) begin
                pk = model_pick(mptr, req_valid, req_rd);
                if (pk.f0) begin
                    m_en0 <= (req_rd[pk.g0] != 0);
                    m_rd0 <= req_rd[pk.g0];
                    m_d0  <= req_data[pk.g0];
                    mptr  <= ((pk.f1 ? pk.g1 : pk.g0) + 1) % N;
                end
                if (pk.f1) begin
                    m_en1 <= (req_rd[pk.g1] != 0);
                    m_rd1 <= req_rd[pk.g1];
                    m_d1  <= req_data[pk.g1];
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("model_ready", 64'(req_ready), 64'(model_ready()));
        check("model_port0", 64'({wb_en0, wb_rd0, wb_data0}), 64'({m_en0, m_rd0, m_d0}));
        check("model_port1", 64'({wb_en1, wb_rd1, wb_data1}), 64'({m_en1, m_rd1, m_d1}));
    end

    // ---------------- directed stimulus ----------------
    // Advance one edge; optionally drop requesters whose handshake completed.
    task automatic step(input bit drop);
        logic [N-1:0] hs;
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (drop) req_valid = req_valid & ~hs;
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_r;
        int           base;

        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = 6'b000001;
        req_rd    = '0;
        req_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_en0", 64'(wb_en0), 64'h0);
        check("rst_data0", 64'(wb_data0), 64'h0);
        check("rst_ptr", 64'(dut.ptr_q), 64'h0);
        req_valid = '0;
        reset     = 1'b0;
        #1;

        // Single requester.
        req_rd[0]   = 5'd5;
        req_data[0] = 32'h11;
        req_valid   = 6'b000001;
        #1;
        check("single_ready", 64'(req_ready), 64'h01);
        step(1);
        check("single_port0", 64'({wb_en0, wb_rd0, wb_data0}), {26'h0, 1'b1, 5'd5, 32'h11});
        check("single_en1", 64'(wb_en1), 64'h0);
        check("single_ptr", 64'(dut.ptr_q), 64'h1);
        pulse_reset();

        // All six continuously valid with distinct destinations.
        for (int i = 0; i < N; i++) begin
            req_rd[i]   = 5'(i + 1);
            req_data[i] = 32'hA0 + 32'(i);
        end
        req_valid = 6'b111111;
        #1;
        for (int c = 0; c < 4; c++) begin
            base  = (c * 2) % N;
            exp_r = 6'b000011;
            exp_r = exp_r << base;
            check("rr_ready", 64'(req_ready), 64'(exp_r));
            step(0);
            check("rr_port0", 64'({wb_en0, wb_rd0, wb_data0}),
                  64'({1'b1, 5'(base + 1), 32'hA0 + 32'(base)}));
            check("rr_port1", 64'({wb_en1, wb_rd1, wb_data1}),
                  64'({1'b1, 5'(base + 2), 32'hA1 + 32'(base)}));
        end

        // Asynchronous reset mid-run while port 0 is writing.
        reset = 1'b1;
        #1;
        check("midrst_en", 64'({wb_en0, wb_en1}), 64'h0);
        check("midrst_rd_data", 64'({wb_rd0, wb_data0, wb_rd1}), 64'h0);
        check("midrst_ready", 64'(req_ready), 64'h0);
        check("midrst_ptr", 64'(dut.ptr_q), 64'h0);
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Destination conflict between MUL1 and MUL2.
        req_rd[2]   = 5'd7; req_data[2] = 32'hA;
        req_rd[3]   = 5'd7; req_data[3] = 32'hB;
        req_valid   = 6'b001100;
        #1;
        check("conf_ready1", 64'(req_ready), 64'h04);
        step(1);
        check("conf_port0a", 64'({wb_en0, wb_rd0, wb_data0}), 64'({1'b1, 5'd7, 32'hA}));
        check("conf_en1a", 64'(wb_en1), 64'h0);
        check("conf_ready2", 64'(req_ready), 64'h08);
        step(1);
        check("conf_port0b", 64'({wb_en0, wb_rd0, wb_data0}), 64'({1'b1, 5'd7, 32'hB}));

        // Destination zero alongside a normal write.
        req_rd[4] = 5'd0; req_data[4] = 32'hFF;
        req_rd[5] = 5'd9; req_data[5] = 32'h22;
        req_valid = 6'b110000;
        #1;
        check("zero_ready", 64'(req_ready), 64'h30);
        step(1);
        check("zero_port0", 64'({wb_en0, wb_rd0, wb_data0}), 64'({1'b0, 5'd0, 32'hFF}));
        check("zero_port1", 64'({wb_en1, wb_rd1, wb_data1}), 64'({1'b1, 5'd9, 32'h22}));

        // Two rd=0 requests in one cycle.
        req_rd[0] = 5'd0; req_data[0] = 32'h1;
        req_rd[1] = 5'd0; req_data[1] = 32'h2;
        req_valid = 6'b000011;
        #1;
        check("zero2_ready", 64'(req_ready), 64'h03);
        step(1);
        check("zero2_en", 64'({wb_en0, wb_en1}), 64'h0);
        check("zero2_data1", 64'(wb_data1), 64'h2);

        // Stall for three cycles with ADD2, MUL1, LOAD2 waiting.
        req_rd[1] = 5'd3; req_data[1] = 32'h31;
        req_rd[2] = 5'd4; req_data[2] = 32'h42;
        req_rd[5] = 5'd6; req_data[5] = 32'h56;
        req_valid = 6'b100110;
        stall     = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("stall_ready", 64'(req_ready), 64'h0);
            step(1);
            check("stall_en", 64'({wb_en0, wb_en1}), 64'h0);
            check("stall_hold", 64'(wb_data0), 64'h1);
            check("stall_ptr", 64'(dut.ptr_q), 64'h2);
        end
        stall = 1'b0;
        #1;
        check("rel_ready", 64'(req_ready), 64'h24);
        step(1);
        check("rel_port0", 64'({wb_en0, wb_rd0, wb_data0}), 64'({1'b1, 5'd4, 32'h42}));
        check("rel_port1", 64'({wb_en1, wb_rd1, wb_data1}), 64'({1'b1, 5'd6, 32'h56}));
        check("rel_ready2", 64'(req_ready), 64'h02);
        step(1);
        check("rel_port0b", 64'({wb_rd0, wb_data0}), 64'({5'd3, 32'h31}));

        // Mixed conflicts; the per-cycle model does the checking here.
        req_rd    = {5'd8, 5'd0, 5'd0, 5'd3, 5'd3, 5'd3};
        req_data  = {32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
        req_valid = 6'b111111;
        repeat (6) step(1);
        check("mix_drained", 64'(req_valid), 64'h0);
        req_rd    = {5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd1};
        req_valid = 6'b101101;
        repeat (2) step(1);
        stall = 1'b1;
        step(1);
        stall = 1'b0;
        repeat (4) step(1);
        check("mix2_drained", 64'(req_valid), 64'h0);

        repeat (2) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
